// File: rtl/lms_pkg.sv
// Shared widths, controller states and the 16-bit saturation helper
// used by the LMS predictor datapath.
package lms_pkg;

  localparam int SAMPLE_W = 16;
  localparam int WEIGHT_W = 16;
  localparam int PROD_W   = 32;
  localparam int ACC_W    = 40;

  typedef enum logic [1:0] {
    IDLE,
    MAC,
    OUT,
    UPDATE
  } state_e;

  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(32767);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-32768);

  // Clamp a sign-extended value into the signed 16-bit range.
  function automatic logic signed [SAMPLE_W-1:0] sat16(input logic signed [ACC_W-1:0] v);
    if (v > SAT_MAX) begin
      sat16 = 16'sh7fff;
    end else if (v < SAT_MIN) begin
      sat16 = 16'sh8000;
    end else begin
      sat16 = v[SAMPLE_W-1:0];
    end
  endfunction

endpackage

// File: rtl/lms_tap_store.sv
// Sample history shift register and adaptive weight file; one indexed
// read port returns tap k's delayed sample and weight together.
module lms_tap_store
  import lms_pkg::*;
#(
  parameter int NTAPS = 16,
  parameter int DELAY = 1,
  parameter int KW    = (NTAPS > 1) ? $clog2(NTAPS) : 1
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       shift_en_i,
  input  logic signed [SAMPLE_W-1:0] x_i,
  input  logic        [KW-1:0]       rd_idx_i,
  output logic signed [SAMPLE_W-1:0] tap_x_o,
  output logic signed [WEIGHT_W-1:0] tap_w_o,
  input  logic                       w_we_i,
  input  logic        [KW-1:0]       w_wr_idx_i,
  input  logic signed [WEIGHT_W-1:0] w_wr_data_i
);

  localparam int HLEN = NTAPS + DELAY;
  localparam int HW   = $clog2(HLEN);

  logic signed [SAMPLE_W-1:0] hist_q [HLEN];
  logic signed [WEIGHT_W-1:0] w_q    [NTAPS];
  logic        [HW-1:0]       hist_idx;

  // Slot 0 holds x[n]; tap k sees x[n-DELAY-k].
  assign hist_idx = HW'(rd_idx_i) + HW'(DELAY);
  assign tap_x_o  = hist_q[hist_idx];
  assign tap_w_o  = w_q[rd_idx_i];

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < HLEN; i++) begin
        hist_q[i] <= '0;
      end
    end else if (shift_en_i) begin
      hist_q[0] <= x_i;
      for (int i = 1; i < HLEN; i++) begin
        hist_q[i] <= hist_q[i-1];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < NTAPS; i++) begin
        w_q[i] <= '0;
      end
    end else if (w_we_i) begin
      w_q[w_wr_idx_i] <= w_wr_data_i;
    end
  end

endmodule

// File: rtl/lms_predictor_core.sv
// Adaptive LMS linear predictor: NTAPS-tap FIR prediction followed by a
// sign-exact LMS weight update, time-multiplexed over one multiplier.
module lms_predictor_core
  import lms_pkg::*;
#(
  parameter int NTAPS    = 16,
  parameter int DELAY    = 1,
  parameter int MU_SHIFT = 16,
  parameter int WFRAC    = 14
) (
  input  logic                       clk_in,
  input  logic                       rst_in,
  input  logic                       ready_in,
  input  logic signed [SAMPLE_W-1:0] x_in,
  output logic signed [SAMPLE_W-1:0] y_out,
  output logic                       done_out
);

  localparam int            KW     = (NTAPS > 1) ? $clog2(NTAPS) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(NTAPS - 1);

  if (2 * NTAPS + 3 > 128) begin : g_budget_check
    $fatal(1, "lms_predictor_core: 2*NTAPS+3 exceeds the 128-cycle sample period");
  end

  state_e                     state_q, state_d;
  logic        [KW-1:0]       k_q, k_d;
  logic                       accept_q, accept_d;
  logic signed [SAMPLE_W-1:0] x_in_q, x_n_q, y_q, e_q;
  logic signed [ACC_W-1:0]    acc_q;
  logic                       done_q;

  logic signed [SAMPLE_W-1:0] tap_x, tap_w, mul_a, y_sat, e_sat, w_new;
  logic signed [PROD_W-1:0]   prod;
  logic signed [ACC_W-1:0]    prod_ext, acc_d, y_full, e_full, w_sum;
  logic                       shift_en, w_we;

  // The strobe is registered first; the sample enters history on the
  // following IDLE cycle, which makes the output land NTAPS+2 edges later.
  assign accept_d = ready_in && (state_q == IDLE) && !accept_q;
  assign shift_en = (state_q == IDLE) && accept_q;
  assign w_we     = (state_q == UPDATE);

  lms_tap_store #(
    .NTAPS (NTAPS),
    .DELAY (DELAY),
    .KW    (KW)
  ) u_tap_store (
    .clk_i       (clk_in),
    .rst_ni      (rst_in),
    .shift_en_i  (shift_en),
    .x_i         (x_in_q),
    .rd_idx_i    (k_q),
    .tap_x_o     (tap_x),
    .tap_w_o     (tap_w),
    .w_we_i      (w_we),
    .w_wr_idx_i  (k_q),
    .w_wr_data_i (w_new)
  );

  // Single shared multiplier: w[k]*x during MAC, e*x during UPDATE.
  assign mul_a    = (state_q == UPDATE) ? e_q : tap_w;
  assign prod     = $signed({{(PROD_W-SAMPLE_W){mul_a[SAMPLE_W-1]}}, mul_a})
                  * $signed({{(PROD_W-SAMPLE_W){tap_x[SAMPLE_W-1]}}, tap_x});
  assign prod_ext = $signed({{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod});
  assign acc_d    = acc_q + prod_ext;

  assign y_full = acc_q >>> WFRAC;
  assign y_sat  = sat16(y_full);
  assign e_full = $signed({{(ACC_W-SAMPLE_W){x_n_q[SAMPLE_W-1]}}, x_n_q})
                - $signed({{(ACC_W-SAMPLE_W){y_sat[SAMPLE_W-1]}}, y_sat});
  assign e_sat  = sat16(e_full);

  assign w_sum = $signed({{(ACC_W-WEIGHT_W){tap_w[WEIGHT_W-1]}}, tap_w}) + (prod_ext >>> MU_SHIFT);
  assign w_new = sat16(w_sum);

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state_q <= IDLE;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
    end
  end

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    case (state_q)
      IDLE: begin
        if (accept_q) begin
          state_d = MAC;
          k_d     = '0;
        end
      end
      MAC: begin
        k_d = k_q + KW'(1);
        if (k_q == K_LAST) begin
          state_d = OUT;
          k_d     = '0;
        end
      end
      OUT: begin
        state_d = UPDATE;
        k_d     = '0;
      end
      UPDATE: begin
        k_d = k_q + KW'(1);
        if (k_q == K_LAST) begin
          state_d = IDLE;
          k_d     = '0;
        end
      end
      default: begin
        state_d = IDLE;
        k_d     = '0;
      end
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      accept_q <= 1'b0;
      x_in_q   <= '0;
      x_n_q    <= '0;
      acc_q    <= '0;
      y_q      <= '0;
      e_q      <= '0;
      done_q   <= 1'b0;
    end else begin
      accept_q <= accept_d;
      done_q   <= 1'b0;
      if (accept_d) begin
        x_in_q <= x_in;
      end
      case (state_q)
        IDLE: begin
          if (accept_q) begin
            x_n_q <= x_in_q;
            acc_q <= '0;
          end
        end
        MAC: begin
          acc_q <= acc_d;
        end
        OUT: begin
          y_q    <= y_sat;
          e_q    <= e_sat;
          done_q <= 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  assign y_out    = y_q;
  assign done_out = done_q;

endmodule

// File: tb/tb_lms_predictor_core.sv
// Randomised self-checking bench for lms_predictor_core: a default instance
// and an aggressive-step instance, both checked against a plain LMS model.
module tb_lms_predictor_core;

  localparam int NTAPS = 16;
  localparam int DELAY = 1;
  localparam int WFRAC = 14;
  localparam int HL    = NTAPS + DELAY;
  localparam int LAT   = NTAPS + 2;

  logic               clk;
  logic               rst_n;
  logic               ready;
  logic signed [15:0] x_drv;
  logic signed [15:0] y0, y1;
  logic               d0, d1;

  int n_tests = 0;
  int n_fail  = 0;
  int obs_y0, obs_y1;

  int m_hist [2][HL];
  int m_w    [2][NTAPS];

  lms_predictor_core #(.NTAPS(NTAPS), .DELAY(DELAY), .MU_SHIFT(16), .WFRAC(WFRAC)) u_dut (
    .clk_in   (clk),
    .rst_in   (rst_n),
    .ready_in (ready),
    .x_in     (x_drv),
    .y_out    (y0),
    .done_out (d0)
  );

  lms_predictor_core #(.NTAPS(NTAPS), .DELAY(DELAY), .MU_SHIFT(8), .WFRAC(WFRAC)) u_sat (
    .clk_in   (clk),
    .rst_in   (rst_n),
    .ready_in (ready),
    .x_in     (x_drv),
    .y_out    (y1),
    .done_out (d1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #5ms;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int clamp16(longint v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return int'(v);
  endfunction

  function automatic void model_reset();
    for (int c = 0; c < 2; c++) begin
      for (int i = 0; i < HL; i++) m_hist[c][i] = 0;
      for (int k = 0; k < NTAPS; k++) m_w[c][k] = 0;
    end
  endfunction

  // One sample of the LMS rules: predict from delayed history, then adapt.
  function automatic int model_step(int c, int x);
    longint acc;
    int     y, e, mu;
    mu = (c == 0) ? 16 : 8;
    for (int i = HL - 1; i > 0; i--) m_hist[c][i] = m_hist[c][i-1];
    m_hist[c][0] = x;
    acc = 0;
    for (int k = 0; k < NTAPS; k++)
      acc += longint'(m_w[c][k]) * longint'(m_hist[c][DELAY+k]);
    y = clamp16(acc >>> WFRAC);
    e = clamp16(longint'(x) - longint'(y));
    for (int k = 0; k < NTAPS; k++)
      m_w[c][k] = clamp16(longint'(m_w[c][k]) + ((longint'(e) * longint'(m_hist[c][DELAY+k])) >>> mu));
    return y;
  endfunction

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  // Sends one sample, waits (bounded) for done, checks latency, width and
  // both outputs; with glitch set, extra strobes hit MAC and UPDATE.
  task automatic do_sample(input int x, input string tag, input bit glitch);
    int ey0, ey1, cnt, extra;
    bit seen;
    ey0 = model_step(0, x);
    ey1 = model_step(1, x);
    @(negedge clk);
    ready = 1'b1;
    x_drv = 16'(x);
    @(negedge clk);
    ready = 1'b0;
    cnt   = 1;
    seen  = 1'b0;
    while (!seen && cnt < 60) begin
      if (d0) begin
        seen = 1'b1;
      end else begin
        @(negedge clk);
        cnt++;
        if (glitch && cnt == 6) begin
          ready = 1'b1;
          x_drv = 16'($urandom_range(0, 65535));
        end
        if (cnt == 7) ready = 1'b0;
      end
    end
    obs_y0 = int'(y0);
    obs_y1 = int'(y1);
    n_tests++;
    if (!seen) begin
      n_fail++;
      $display("[TB] FAIL %s done_timeout: no done_out within %0d cycles", tag, cnt);
      return;
    end
    $display("[TB] %s x=%0d y=%0d (exp %0d) ysat=%0d (exp %0d) lat=%0d", tag, x, obs_y0, ey0, obs_y1, ey1, cnt - 1);
    if ((cnt - 1) !== LAT) begin
      n_fail++;
      $display("[TB] FAIL %s latency: got %0d expected %0d", tag, cnt - 1, LAT);
    end
    n_tests++;
    if (y0 !== 16'(ey0)) begin
      n_fail++;
      $display("[TB] FAIL %s y_out: got %0d expected %0d", tag, obs_y0, ey0);
    end
    n_tests++;
    if (d1 !== 1'b1 || y1 !== 16'(ey1)) begin
      n_fail++;
      $display("[TB] FAIL %s sat_y_out: got %0d (done %0b) expected %0d (done 1)", tag, obs_y1, d1, ey1);
    end
    @(negedge clk);
    n_tests++;
    if (d0 !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL %s done_width: got %0b expected 0", tag, d0);
    end
    extra = 0;
    for (int i = 0; i < (glitch ? 45 : 18); i++) begin
      @(negedge clk);
      if (glitch && i == 4) begin
        ready = 1'b1;
        x_drv = 16'($urandom_range(0, 65535));
      end
      if (i == 5) ready = 1'b0;
      if (d0 || d1) extra++;
    end
    if (glitch) begin
      n_tests++;
      if (extra !== 0) begin
        n_fail++;
        $display("[TB] FAIL %s extra_done: got %0d pulses expected 0", tag, extra);
      end
    end
  endtask

  task automatic test_reset();
    apply_reset();
    n_tests++;
    if (y0 !== 16'sd0 || d0 !== 1'b0 || y1 !== 16'sd0 || d1 !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL reset_state: got y=%0d d=%0b ysat=%0d dsat=%0b expected all 0", y0, d0, y1, d1);
    end
  endtask

  task automatic test_first_sample();
    apply_reset();
    do_sample(1000, "first", 1'b0);
    n_tests++;
    if (obs_y0 !== 0) begin
      n_fail++;
      $display("[TB] FAIL first_y: got %0d expected 0", obs_y0);
    end
  endtask

  task automatic test_constant_pos();
    apply_reset();
    for (int n = 0; n < 150; n++) do_sample(1000, "const_pos", 1'b0);
  endtask

  task automatic test_constant_neg();
    int first_nz;
    first_nz = 0;
    apply_reset();
    for (int n = 0; n < 100; n++) begin
      do_sample(-1000, "const_neg", 1'b0);
      if (first_nz == 0 && obs_y0 != 0) first_nz = obs_y0;
    end
    n_tests++;
    if (first_nz !== -1) begin
      n_fail++;
      $display("[TB] FAIL neg_floor: first nonzero y got %0d expected -1", first_nz);
    end
  endtask

  task automatic test_sine();
    int x;
    apply_reset();
    for (int n = 0; n < 300; n++) begin
      x = 1700 + $rtoi($floor(512.0 * $sin(6.283185307 * n / 50.0) + 0.5))
        + int'($urandom_range(0, 6)) - 3;
      do_sample(x, "sine", 1'b0);
    end
  endtask

  task automatic test_random();
    apply_reset();
    for (int n = 0; n < 60; n++)
      do_sample(int'($urandom_range(0, 65535)) - 32768, "random", 1'b0);
  endtask

  task automatic test_saturation();
    apply_reset();
    for (int n = 0; n < 30; n++) do_sample(32767, "saturate", 1'b0);
    n_tests++;
    if (obs_y1 !== 32767) begin
      n_fail++;
      $display("[TB] FAIL sat_clamp: got %0d expected 32767", obs_y1);
    end
  endtask

  task automatic test_back_to_back();
    apply_reset();
    do_sample(1200, "proto_pre", 1'b0);
    do_sample(-700, "proto_glitch", 1'b1);
    do_sample(900, "proto_glitch", 1'b1);
    do_sample(400, "proto_post", 1'b0);
  endtask

  task automatic test_reset_mid_update();
    int cnt;
    apply_reset();
    for (int n = 0; n < 20; n++) do_sample(1000, "pre_reset", 1'b0);
    @(negedge clk);
    ready = 1'b1;
    x_drv = 16'sd1000;
    @(negedge clk);
    ready = 1'b0;
    cnt = 1;
    while (!d0 && cnt < 60) begin
      @(negedge clk);
      cnt++;
    end
    n_tests++;
    if (!d0) begin
      n_fail++;
      $display("[TB] FAIL mid_reset_wait: no done_out within %0d cycles", cnt);
    end
    repeat (5) @(negedge clk);
    apply_reset();
    n_tests++;
    if (y0 !== 16'sd0 || d0 !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL mid_reset_clear: got y=%0d d=%0b expected 0 0", y0, d0);
    end
    repeat (40) @(negedge clk);
    do_sample(777, "post_reset", 1'b0);
    n_tests++;
    if (obs_y0 !== 0) begin
      n_fail++;
      $display("[TB] FAIL post_reset_y: got %0d expected 0", obs_y0);
    end
  endtask

  initial begin
    rst_n = 1'b1;
    ready = 1'b0;
    x_drv = '0;
    model_reset();
    repeat (2) @(negedge clk);
    test_reset();
    test_first_sample();
    test_constant_pos();
    test_constant_neg();
    test_sine();
    test_random();
    test_saturation();
    test_back_to_back();
    test_reset_mid_update();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
